// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO.
//   clog2           : ceiling log2 for sizing pointers and addresses
//   ingress_state_e : ingress FSM states (between frames / inside a frame / discarding)
package axis_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StFrame,
        StDrop
    } ingress_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset on the array.
//   clk_i      clock
//   wr_en_i    write strobe, wr_addr_i / wr_data_i written on the rising edge
//   rd_en_i    read strobe, rd_data_o updated one edge after rd_addr_i; holds otherwise
module sdp_ram
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      wr_en_i,
    input  logic [clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [WIDTH-1:0]          wr_data_i,
    input  logic                      rd_en_i,
    input  logic [clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [WIDTH-1:0]          rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO with store-and-forward, whole-frame drop on overflow, bad-frame drop
// and statistics counters. Cut-through mode behaves as a plain FIFO.
//   clk_i / resetn_i       clock, asynchronous active-low reset
//   s_axis_*               ingress stream (tuser sampled on the tlast beat)
//   m_axis_*               egress stream from a one-entry output register
//   fill_level_o           committed beats held (including beats already prefetched)
//   pkt_cnt_o              frames committed
//   drop_cnt_o             frames discarded (overflow + bad), saturating
//   overflow_o             one-cycle pulse when a frame is discarded for lack of space
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH   = 64,
    parameter int unsigned KEEP_WIDTH        = AXIS_DATA_WIDTH / 8,
    parameter int unsigned DEPTH             = 512,
    parameter bit          STORE_AND_FORWARD = 1'b1,
    parameter bit          DROP_WHEN_FULL    = 1'b1,
    parameter bit          DROP_BAD_FRAME    = 1'b1,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       s_axis_tvalid_i,
    output logic                       s_axis_tready_o,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep_i,
    input  logic                       s_axis_tlast_i,
    input  logic                       s_axis_tuser_i,
    output logic                       m_axis_tvalid_o,
    input  logic                       m_axis_tready_i,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep_o,
    output logic                       m_axis_tlast_o,
    output logic                       m_axis_tuser_o,
    output logic [clog2(DEPTH):0]      fill_level_o,
    output logic [CNT_WIDTH-1:0]       pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]       drop_cnt_o,
    output logic                       overflow_o
);

    localparam int unsigned AW       = clog2(DEPTH);
    localparam int unsigned PW       = AW + 1;
    localparam int unsigned RW       = AXIS_DATA_WIDTH + KEEP_WIDTH + 2;
    localparam int unsigned LAST_BIT = AXIS_DATA_WIDTH + KEEP_WIDTH;
    localparam int unsigned USER_BIT = AXIS_DATA_WIDTH + KEEP_WIDTH + 1;
    // Frame dropping only makes sense when frames are held back until tlast.
    localparam bit SAF       = STORE_AND_FORWARD;
    localparam bit DROP_FULL = STORE_AND_FORWARD && DROP_WHEN_FULL;
    localparam bit DROP_BAD  = STORE_AND_FORWARD && DROP_BAD_FRAME;

    ingress_state_e       state_q;
    logic [PW-1:0]        wr_cur_q, wr_commit_q, rd_q, fetch_q, fill_q;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, drop_cnt_q;
    logic                 overflow_q, ready_en_q;
    logic                 ram_valid_q, out_valid_q;
    logic [RW-1:0]        out_q;
    logic [RW-1:0]        ram_rdata;

    logic          full, empty, s_fire, m_fire, out_ready, rd_en, wr_en;
    logic [PW-1:0] avail_end;

    // rd_q retires beats only when they leave the output register, so slots still sitting in
    // the prefetch pipeline are never overwritten; fetch_q is the RAM read address.
    assign full      = (wr_cur_q - rd_q) == PW'(DEPTH);
    assign avail_end = SAF ? wr_commit_q : wr_cur_q;
    assign empty     = (fetch_q == avail_end);

    assign s_axis_tready_o = ready_en_q & (DROP_FULL | ~full);
    assign s_fire          = s_axis_tvalid_i & s_axis_tready_o;
    assign wr_en           = s_fire && (state_q != StDrop) && !(DROP_FULL && full);

    assign m_fire    = out_valid_q & m_axis_tready_i;
    assign out_ready = ~out_valid_q | m_axis_tready_i;
    assign rd_en     = ~empty & (~ram_valid_q | out_ready);

    sdp_ram #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_cur_q[AW-1:0]),
        .wr_data_i ({s_axis_tuser_i, s_axis_tlast_i, s_axis_tkeep_i, s_axis_tdata_i}),
        .rd_en_i   (rd_en),
        .rd_addr_i (fetch_q[AW-1:0]),
        .rd_data_o (ram_rdata)
    );

    // Ingress FSM, write pointers and statistics.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= StIdle;
            wr_cur_q    <= '0;
            wr_commit_q <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            overflow_q <= 1'b0;
            if (s_fire) begin
                case (state_q)
                    StIdle, StFrame: begin
                        if (DROP_FULL && full) begin
                            // Rewind to the last committed frame and discard the rest.
                            wr_cur_q   <= wr_commit_q;
                            overflow_q <= 1'b1;
                            if (drop_cnt_q != {CNT_WIDTH{1'b1}}) drop_cnt_q <= drop_cnt_q + 1'b1;
                            state_q    <= s_axis_tlast_i ? StIdle : StDrop;
                        end else if (s_axis_tlast_i) begin
                            state_q <= StIdle;
                            if (DROP_BAD && s_axis_tuser_i) begin
                                wr_cur_q <= wr_commit_q;
                                if (drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
                                    drop_cnt_q <= drop_cnt_q + 1'b1;
                                end
                            end else begin
                                wr_cur_q    <= wr_cur_q + 1'b1;
                                wr_commit_q <= wr_cur_q + 1'b1;
                                pkt_cnt_q   <= pkt_cnt_q + 1'b1;
                            end
                        end else begin
                            wr_cur_q <= wr_cur_q + 1'b1;
                            state_q  <= StFrame;
                        end
                    end
                    StDrop: begin
                        if (s_axis_tlast_i) state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Egress: RAM read stage followed by the output register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            fetch_q     <= '0;
            rd_q        <= '0;
            ram_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            fill_q      <= '0;
        end else begin
            if (rd_en)  fetch_q <= fetch_q + 1'b1;
            if (m_fire) rd_q    <= rd_q + 1'b1;
            if (rd_en) begin
                ram_valid_q <= 1'b1;
            end else if (out_ready) begin
                ram_valid_q <= 1'b0;
            end
            if (out_ready) begin
                out_valid_q <= ram_valid_q;
                if (ram_valid_q) out_q <= ram_rdata;
            end
            // Follows the pointers one cycle behind.
            fill_q <= avail_end - rd_q;
        end
    end

    assign m_axis_tvalid_o = out_valid_q;
    assign m_axis_tdata_o  = out_q[AXIS_DATA_WIDTH-1:0];
    assign m_axis_tkeep_o  = out_q[LAST_BIT-1:AXIS_DATA_WIDTH];
    assign m_axis_tlast_o  = out_q[LAST_BIT];
    assign m_axis_tuser_o  = SAF ? 1'b0 : out_q[USER_BIT];
    assign fill_level_o    = fill_q;
    assign pkt_cnt_o       = pkt_cnt_q;
    assign drop_cnt_o      = drop_cnt_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: three instances (512-deep drop-capable, 16-deep drop-capable,
// 16-deep backpressure-only) fed by a shared clock and reset.
module tb_axis_pkt_fifo;

    logic        clk;
    logic        resetn;
    logic        s_tvalid [3];
    logic        s_tready [3];
    logic [63:0] s_tdata  [3];
    logic [7:0]  s_tkeep  [3];
    logic        s_tlast  [3];
    logic        s_tuser  [3];
    logic        m_tvalid [3];
    logic        m_tready [3];
    logic [63:0] m_tdata  [3];
    logic [7:0]  m_tkeep  [3];
    logic        m_tlast  [3];
    logic        m_tuser  [3];
    logic [31:0] pkt_cnt  [3];
    logic [31:0] drop_cnt [3];
    logic        overflow [3];
    logic [9:0]  fill0;
    logic [4:0]  fill1;
    logic [4:0]  fill2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q   [3][$];
    int         exp_len [3][$];
    logic [7:0] rx_q    [3][$];
    int ovf_cnt   [3];
    int extra_cnt [3];
    int user_err  = 0;
    int cyc       = 0;
    int acc2      = 0;
    int pop2      = 0;
    int rdy_err   = 0;
    int full_seen = 0;
    int early_err = 0;
    bit chk_rdy   = 0;
    bit watch_early = 0;
    bit tmo       = 0;
    bit rnd_run   = 0;

    axis_pkt_fifo #(.DEPTH(512)) u_dut0 (
        .clk_i(clk), .resetn_i(resetn),
        .s_axis_tvalid_i(s_tvalid[0]), .s_axis_tready_o(s_tready[0]),
        .s_axis_tdata_i(s_tdata[0]), .s_axis_tkeep_i(s_tkeep[0]),
        .s_axis_tlast_i(s_tlast[0]), .s_axis_tuser_i(s_tuser[0]),
        .m_axis_tvalid_o(m_tvalid[0]), .m_axis_tready_i(m_tready[0]),
        .m_axis_tdata_o(m_tdata[0]), .m_axis_tkeep_o(m_tkeep[0]),
        .m_axis_tlast_o(m_tlast[0]), .m_axis_tuser_o(m_tuser[0]),
        .fill_level_o(fill0), .pkt_cnt_o(pkt_cnt[0]), .drop_cnt_o(drop_cnt[0]),
        .overflow_o(overflow[0])
    );

    axis_pkt_fifo #(.DEPTH(16)) u_dut1 (
        .clk_i(clk), .resetn_i(resetn),
        .s_axis_tvalid_i(s_tvalid[1]), .s_axis_tready_o(s_tready[1]),
        .s_axis_tdata_i(s_tdata[1]), .s_axis_tkeep_i(s_tkeep[1]),
        .s_axis_tlast_i(s_tlast[1]), .s_axis_tuser_i(s_tuser[1]),
        .m_axis_tvalid_o(m_tvalid[1]), .m_axis_tready_i(m_tready[1]),
        .m_axis_tdata_o(m_tdata[1]), .m_axis_tkeep_o(m_tkeep[1]),
        .m_axis_tlast_o(m_tlast[1]), .m_axis_tuser_o(m_tuser[1]),
        .fill_level_o(fill1), .pkt_cnt_o(pkt_cnt[1]), .drop_cnt_o(drop_cnt[1]),
        .overflow_o(overflow[1])
    );

    axis_pkt_fifo #(.DEPTH(16), .DROP_WHEN_FULL(1'b0)) u_dut2 (
        .clk_i(clk), .resetn_i(resetn),
        .s_axis_tvalid_i(s_tvalid[2]), .s_axis_tready_o(s_tready[2]),
        .s_axis_tdata_i(s_tdata[2]), .s_axis_tkeep_i(s_tkeep[2]),
        .s_axis_tlast_i(s_tlast[2]), .s_axis_tuser_i(s_tuser[2]),
        .m_axis_tvalid_o(m_tvalid[2]), .m_axis_tready_i(m_tready[2]),
        .m_axis_tdata_o(m_tdata[2]), .m_axis_tkeep_o(m_tkeep[2]),
        .m_axis_tlast_o(m_tlast[2]), .m_axis_tuser_o(m_tuser[2]),
        .fill_level_o(fill2), .pkt_cnt_o(pkt_cnt[2]), .drop_cnt_o(drop_cnt[2]),
        .overflow_o(overflow[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] pat(input int seed, input int i);
        return 8'((seed * 37 + i * 3 + (i >> 8)) & 255);
    endfunction

    function automatic int get_fill(input int d);
        if (d == 0) return int'(fill0);
        if (d == 1) return int'(fill1);
        return int'(fill2);
    endfunction

    function automatic bit any_out(input int d);
        return m_tvalid[d] | s_tready[d] | (|m_tdata[d]) | (|m_tkeep[d]) | m_tlast[d]
             | m_tuser[d] | overflow[d] | (|pkt_cnt[d]) | (|drop_cnt[d]) | (get_fill(d) != 0);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called and returns at one time unit after a rising edge.
    task automatic send_frame(input int d, input int nbytes, input int seed, input bit bad,
                              input bit keep_exp, input bit bubbles);
        int          nbeats;
        int          waited;
        logic [63:0] data;
        logic [7:0]  keep;
        nbeats = (nbytes + 7) / 8;
        if (keep_exp) begin
            for (int i = 0; i < nbytes; i++) exp_q[d].push_back(pat(seed, i));
            exp_len[d].push_back(nbytes);
        end
        for (int b = 0; b < nbeats; b++) begin
            if (bubbles) begin
                while ($urandom_range(0, 1) == 0) begin
                    s_tvalid[d] = 1'b0;
                    tick(1);
                end
            end
            for (int k = 0; k < 8; k++) begin
                keep[k]        = (b * 8 + k) < nbytes;
                data[k*8 +: 8] = keep[k] ? pat(seed, b * 8 + k) : 8'hee;
            end
            s_tdata[d]  = data;
            s_tkeep[d]  = keep;
            s_tlast[d]  = (b == nbeats - 1);
            s_tuser[d]  = bad && (b == nbeats - 1);
            s_tvalid[d] = 1'b1;
            waited = 0;
            while (!s_tready[d] && !tmo) begin
                tick(1);
                waited++;
                if (waited > 2000) begin
                    tmo = 1'b1;
                    check("ingress_ready_timeout", 0, 1);
                end
            end
            if (tmo) break;
            tick(1);
        end
        s_tvalid[d] = 1'b0;
        s_tlast[d]  = 1'b0;
        s_tuser[d]  = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (exp_len[d].size() != 0 && n < 20000) begin
            tick(1);
            n++;
        end
        check($sformatf("drain_frames_left_dut%0d", d), exp_len[d].size(), 0);
    endtask

    // Egress scoreboard and per-cycle observations, sampled mid-cycle.
    always @(negedge clk) begin
        int len;
        int got_len;
        int nbad;
        logic [7:0] e;
        cyc++;
        if (resetn) begin
            for (int d = 0; d < 3; d++) begin
                if (overflow[d]) ovf_cnt[d]++;
                if (d == 2) begin
                    if (chk_rdy) begin
                        if (s_tready[2] != ((acc2 - pop2) != 16)) rdy_err++;
                        if (acc2 - pop2 == 16) full_seen++;
                    end
                    if (s_tvalid[2] && s_tready[2]) acc2++;
                    if (m_tvalid[2] && m_tready[2]) pop2++;
                end
                if (d == 0 && watch_early && m_tvalid[0]) early_err++;
                if (m_tvalid[d] && m_tready[d]) begin
                    if (m_tuser[d]) user_err++;
                    for (int k = 0; k < 8; k++) begin
                        if (m_tkeep[d][k]) rx_q[d].push_back(m_tdata[d][k*8 +: 8]);
                    end
                    if (m_tlast[d]) begin
                        if (exp_len[d].size() == 0) begin
                            extra_cnt[d]++;
                        end else begin
                            len     = exp_len[d].pop_front();
                            got_len = rx_q[d].size();
                            nbad    = 0;
                            for (int i = 0; i < len; i++) begin
                                e = exp_q[d].pop_front();
                                if (i >= got_len || rx_q[d][i] != e) nbad++;
                            end
                            check($sformatf("frame_len_dut%0d", d), got_len, len);
                            check($sformatf("frame_bytes_bad_dut%0d", d), nbad, 0);
                        end
                        rx_q[d].delete();
                    end
                end
            end
        end
    end

    typedef struct {
        int nbytes;
        bit bad;
        int exp_pkt;
        int exp_drop;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        vecs[0] = '{nbytes: 64,   bad: 1'b0, exp_pkt: 1, exp_drop: 0};
        vecs[1] = '{nbytes: 65,   bad: 1'b0, exp_pkt: 2, exp_drop: 0};
        vecs[2] = '{nbytes: 1500, bad: 1'b0, exp_pkt: 3, exp_drop: 0};
        vecs[3] = '{nbytes: 32,   bad: 1'b1, exp_pkt: 3, exp_drop: 1};

        resetn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            s_tvalid[d] = 1'b0; s_tdata[d] = '0; s_tkeep[d] = '0;
            s_tlast[d]  = 1'b0; s_tuser[d] = 1'b0; m_tready[d] = 1'b0;
            ovf_cnt[d]  = 0;    extra_cnt[d] = 0;
        end
        #12;
        for (int d = 0; d < 3; d++) check($sformatf("reset_outputs_dut%0d", d), any_out(d), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("ready_low_at_release", s_tready[0], 0);
        tick(1);
        check("ready_high_after_release", s_tready[0], 1);

        // Table: frames through the 512-deep instance with tready held high.
        m_tready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_frame(0, vecs[i].nbytes, i + 1, vecs[i].bad, !vecs[i].bad, 1'b0);
            wait_drain(0);
            tick(4);
            check($sformatf("vec%0d_pkt_cnt", i), pkt_cnt[0], vecs[i].exp_pkt);
            check($sformatf("vec%0d_drop_cnt", i), drop_cnt[0], vecs[i].exp_drop);
            check($sformatf("vec%0d_fill", i), fill0, 0);
            check($sformatf("vec%0d_overflow_pulses", i), ovf_cnt[0], 0);
        end

        // Store-and-forward latency: nothing before tlast, first beat three cycles after it.
        early_err   = 0;
        watch_early = 1'b1;
        send_frame(0, 64, 9, 1'b0, 1'b1, 1'b0);
        watch_early = 1'b0;
        check("saf_valid_before_tlast", early_err, 0);
        check("saf_valid_cycle_n1", m_tvalid[0], 0);
        tick(1);
        check("saf_valid_cycle_n2", m_tvalid[0], 0);
        tick(1);
        check("saf_valid_cycle_n3", m_tvalid[0], 1);
        wait_drain(0);
        tick(4);
        check("saf_pkt_cnt", pkt_cnt[0], 4);

        // Overflow: 16-deep, egress stalled, second 10-beat frame cannot fit.
        send_frame(1, 80, 20, 1'b0, 1'b1, 1'b0);
        send_frame(1, 80, 21, 1'b0, 1'b0, 1'b0);
        tick(3);
        check("ovf_overflow_pulses", ovf_cnt[1], 1);
        check("ovf_drop_cnt", drop_cnt[1], 1);
        check("ovf_pkt_cnt", pkt_cnt[1], 1);
        check("ovf_fill", fill1, 10);
        check("ovf_ready_stays_high", s_tready[1], 1);
        m_tready[1] = 1'b1;
        wait_drain(1);
        tick(20);
        check("ovf_fill_after_drain", fill1, 0);
        check("ovf_extra_frames", extra_cnt[1], 0);

        // Backpressure-only instance: random valid/ready, 200 frames.
        rnd_run = 1'b1;
        chk_rdy = 1'b1;
        fork
            begin
                for (int f = 0; f < 200; f++) begin
                    send_frame(2, $urandom_range(1, 100), f + 100, 1'b0, 1'b1, 1'b1);
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    @(posedge clk);
                    #1;
                    // Periodic stalls make sure the FIFO actually reaches full.
                    m_tready[2] = ($urandom_range(0, 1) == 1) && ((cyc % 256) >= 48);
                end
            end
        join
        m_tready[2] = 1'b1;
        wait_drain(2);
        tick(4);
        chk_rdy = 1'b0;
        check("bp_ready_vs_level_errors", rdy_err, 0);
        check("bp_full_reached", full_seen > 0, 1);
        check("bp_pkt_cnt", pkt_cnt[2], 200);
        check("bp_drop_cnt", drop_cnt[2], 0);
        check("bp_extra_frames", extra_cnt[2], 0);

        // Reset in the middle of a frame with a committed frame waiting at the output.
        m_tready[0] = 1'b0;
        send_frame(0, 40, 30, 1'b0, 1'b1, 1'b0);
        tick(4);
        s_tdata[0]  = 64'h0123_4567_89ab_cdef;
        s_tkeep[0]  = 8'hff;
        s_tlast[0]  = 1'b0;
        s_tvalid[0] = 1'b1;
        tick(1);
        check("pre_reset_valid", m_tvalid[0], 1);
        resetn = 1'b0;
        #1;
        check("reset_mid_frame_outputs", any_out(0), 0);
        s_tvalid[0] = 1'b0;
        exp_q[0].delete();
        exp_len[0].delete();
        rx_q[0].delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("post_reset_ready_low", s_tready[0], 0);
        tick(1);
        check("post_reset_ready_high", s_tready[0], 1);
        m_tready[0] = 1'b1;
        send_frame(0, 100, 31, 1'b0, 1'b1, 1'b0);
        wait_drain(0);
        tick(20);
        check("post_reset_pkt_cnt", pkt_cnt[0], 1);
        check("post_reset_drop_cnt", drop_cnt[0], 0);
        check("post_reset_fill", fill0, 0);
        check("extra_frames_dut0", extra_cnt[0], 0);
        check("saf_tuser_nonzero", user_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
